// File: rtl/argmin_disp_sched_if.sv
// rtl/argmin_disp_sched_if.sv - beat input / result output bundle for argmin_disp_sched
// master drives beats and out_ready; slave (the scheduler) drives in_ready and the result.

interface argmin_disp_sched_if #(
  parameter int WIDTH = 8,
  parameter int BEATS = 8
);
  localparam int DISP_BITS = $clog2(8 * BEATS);

  logic                 in_valid;
  logic                 in_ready;
  logic [8*WIDTH-1:0]   in_words;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_value;
  logic [DISP_BITS-1:0] out_disp;

  modport master (
    output in_valid,
    output in_words,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_value,
    input  out_disp
  );

  modport slave (
    input  in_valid,
    input  in_words,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_value,
    output out_disp
  );
endinterface

// File: rtl/argmin_disp_sched.sv
// rtl/argmin_disp_sched.sv - running argmin over BEATS beats of 8 costs per pixel
// Optional macro ARGMIN_BEAT_PIPE_EN registers the per-beat argmin before the running-min fold.

module argmin_8 #(
  parameter int WIDTH = 8
) (
  input  logic [8*WIDTH-1:0] words_i,
  output logic [WIDTH-1:0]   min_o,
  output logic [2:0]         lane_o
);
  logic [WIDTH-1:0] v1 [4];
  logic [2:0]       l1 [4];
  logic [WIDTH-1:0] v2 [2];
  logic [2:0]       l2 [2];

  // Each node keeps its left (lower-lane) input unless the right one is strictly smaller.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if (words_i[WIDTH*(2*i+1) +: WIDTH] < words_i[WIDTH*(2*i) +: WIDTH]) begin
        v1[i] = words_i[WIDTH*(2*i+1) +: WIDTH];
        l1[i] = 3'(2*i+1);
      end else begin
        v1[i] = words_i[WIDTH*(2*i) +: WIDTH];
        l1[i] = 3'(2*i);
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (v1[2*i+1] < v1[2*i]) begin
        v2[i] = v1[2*i+1];
        l2[i] = l1[2*i+1];
      end else begin
        v2[i] = v1[2*i];
        l2[i] = l1[2*i];
      end
    end
    if (v2[1] < v2[0]) begin
      min_o  = v2[1];
      lane_o = l2[1];
    end else begin
      min_o  = v2[0];
      lane_o = l2[0];
    end
  end
endmodule

module argmin_disp_sched #(
  parameter int WIDTH = 8,
  parameter int BEATS = 8
) (
  input logic                clk,
  input logic                rst,
  argmin_disp_sched_if.slave bus
);
  localparam int DISP_BITS = $clog2(8 * BEATS);
  localparam int CNT_BITS  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_BITS-1:0] LAST_B = CNT_BITS'(BEATS - 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t               state_q, state_d;
  logic [CNT_BITS-1:0]  b_q, b_d;
  logic [WIDTH-1:0]     run_val_q, run_val_d;
  logic [DISP_BITS-1:0] run_disp_q, run_disp_d;
  logic [WIDTH-1:0]     out_value_q, out_value_d;
  logic [DISP_BITS-1:0] out_disp_q, out_disp_d;

  logic [WIDTH-1:0]     beat_min;
  logic [2:0]           beat_lane;
  logic                 accept;
  logic                 in_ready;

  logic                 f_valid;
  logic [WIDTH-1:0]     f_val;
  logic [2:0]           f_lane;
  logic [CNT_BITS-1:0]  f_b;
  logic                 f_last;
  logic [DISP_BITS-1:0] f_disp;
  logic                 take;
  logic [WIDTH-1:0]     new_val;
  logic [DISP_BITS-1:0] new_disp;

  argmin_8 #(.WIDTH(WIDTH)) u_argmin_8 (
    .words_i (bus.in_words),
    .min_o   (beat_min),
    .lane_o  (beat_lane)
  );

  assign accept = bus.in_valid && in_ready;

`ifdef ARGMIN_BEAT_PIPE_EN
  logic                p_valid_q, p_valid_d;
  logic [WIDTH-1:0]    p_val_q, p_val_d;
  logic [2:0]          p_lane_q, p_lane_d;
  logic [CNT_BITS-1:0] p_b_q, p_b_d;
  logic                p_last_q, p_last_d;

  always_comb begin
    p_valid_d = accept;
    p_val_d   = p_val_q;
    p_lane_d  = p_lane_q;
    p_b_d     = p_b_q;
    p_last_d  = p_last_q;
    if (accept) begin
      p_val_d  = beat_min;
      p_lane_d = beat_lane;
      p_b_d    = b_q;
      p_last_d = (b_q == LAST_B);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_valid_q <= 1'b0;
      p_val_q   <= '0;
      p_lane_q  <= '0;
      p_b_q     <= '0;
      p_last_q  <= 1'b0;
    end else begin
      p_valid_q <= p_valid_d;
      p_val_q   <= p_val_d;
      p_lane_q  <= p_lane_d;
      p_b_q     <= p_b_d;
      p_last_q  <= p_last_d;
    end
  end

  assign f_valid = p_valid_q;
  assign f_val   = p_val_q;
  assign f_lane  = p_lane_q;
  assign f_b     = p_b_q;
  assign f_last  = p_last_q;
  // A staged last beat still has to be folded, so stop taking beats until it lands.
  assign in_ready = (state_q == ACCUM) && !(p_valid_q && p_last_q);
`else
  assign f_valid  = accept;
  assign f_val    = beat_min;
  assign f_lane   = beat_lane;
  assign f_b      = b_q;
  assign f_last   = (b_q == LAST_B);
  assign in_ready = (state_q == ACCUM);
`endif

  // {beat, lane} is exactly beat*8 + lane, and beat < BEATS keeps it inside DISP_BITS.
  assign f_disp   = DISP_BITS'({f_b, f_lane});
  assign take     = (f_b == '0) || (f_val < run_val_q);
  assign new_val  = take ? f_val  : run_val_q;
  assign new_disp = take ? f_disp : run_disp_q;

  always_comb begin
    state_d     = state_q;
    b_d         = b_q;
    run_val_d   = run_val_q;
    run_disp_d  = run_disp_q;
    out_value_d = out_value_q;
    out_disp_d  = out_disp_q;
    if (accept) begin
      b_d = (b_q == LAST_B) ? '0 : b_q + CNT_BITS'(1);
    end
    case (state_q)
      ACCUM: begin
        if (f_valid) begin
          run_val_d  = new_val;
          run_disp_d = new_disp;
          if (f_last) begin
            out_value_d = new_val;
            out_disp_d  = new_disp;
            state_d     = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      b_q         <= '0;
      run_val_q   <= '0;
      run_disp_q  <= '0;
      out_value_q <= '0;
      out_disp_q  <= '0;
    end else begin
      state_q     <= state_d;
      b_q         <= b_d;
      run_val_q   <= run_val_d;
      run_disp_q  <= run_disp_d;
      out_value_q <= out_value_d;
      out_disp_q  <= out_disp_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_value = out_value_q;
  assign bus.out_disp  = out_disp_q;
endmodule
